// File: rtl/wb_vector_serializer.sv
// Write-back serializer: scalar results go to the 32-bit bank in one cycle, and vector
// results go out as LANES 8-bit lane writes. Define WB_LANE_MSB_FIRST_EN to emit the highest lane first.
module wb_vector_serializer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned VEC_W  = 40,
    parameter int unsigned LANE_W = 8,
    parameter int unsigned LANES  = 5,
    parameter int unsigned REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_we_c,
    input  logic              in_we_v,
    input  logic              in_sel_dat,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [VEC_W-1:0]  in_vec_res,
    input  logic [REG_AW-1:0] in_rg,
    output logic [REG_AW-1:0] Rg_WB,
    output logic [DATA_W-1:0] DinC,
    output logic              WE_C,
    output logic [LANE_W-1:0] DinV_8bit,
    output logic              WE_V,
    output logic [2:0]        wb_lane,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCALAR = 2'd1,
        VEC    = 2'd2
    } state_t;

`ifdef WB_LANE_MSB_FIRST_EN
    localparam logic [2:0] FIRST_LANE = 3'(LANES - 1);
    localparam logic [2:0] LAST_LANE  = 3'd0;
`else
    localparam logic [2:0] FIRST_LANE = 3'd0;
    localparam logic [2:0] LAST_LANE  = 3'(LANES - 1);
`endif

    state_t              state_q, state_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic [REG_AW-1:0]   rg_d;
    logic [DATA_W-1:0]   dinc_d;
    logic                we_c_d, we_v_d, busy_d;
    logic [LANE_W-1:0]   dinv_d;
    logic [2:0]          lane_d, lane_step;
    logic                accept, load;

    function automatic logic [LANE_W-1:0] lane_slice(input logic [VEC_W-1:0] v,
                                                     input logic [2:0] l);
        return LANE_W'(v >> (LANE_W * 32'(l)));
    endfunction

    // Ready is a decode of registered state only.
    assign in_ready = (state_q == IDLE) || (state_q == SCALAR) ||
                      ((state_q == VEC) && (wb_lane == LAST_LANE));
    assign accept   = in_valid && in_ready;

`ifdef WB_LANE_MSB_FIRST_EN
    assign lane_step = wb_lane - 3'd1;
`else
    assign lane_step = wb_lane + 3'd1;
`endif

    // Next-state and next-output decode.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        rg_d    = Rg_WB;
        dinc_d  = DinC;
        dinv_d  = DinV_8bit;
        lane_d  = wb_lane;
        we_c_d  = 1'b0;
        we_v_d  = 1'b0;
        busy_d  = 1'b0;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) load = 1'b1;
            end
            SCALAR: begin
                if (accept) load = 1'b1;
                else        state_d = IDLE;
            end
            VEC: begin
                if (wb_lane != LAST_LANE) begin
                    lane_d = lane_step;
                    dinv_d = lane_slice(vec_q, lane_step);
                    we_v_d = 1'b1;
                    busy_d = 1'b1;
                end else if (accept) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                    lane_d  = 3'd0;
                end
            end
            default: begin
                state_d = IDLE;
                lane_d  = 3'd0;
            end
        endcase

        // Capture an accepted result and launch its first write.
        if (load) begin
            rg_d   = in_rg;
            we_c_d = in_we_c;
            if (in_we_c) dinc_d = in_sel_dat ? in_mem_data : in_alu_res;
            if (in_we_v) begin
                state_d = VEC;
                vec_d   = in_vec_res;
                lane_d  = FIRST_LANE;
                dinv_d  = lane_slice(in_vec_res, FIRST_LANE);
                we_v_d  = 1'b1;
                busy_d  = 1'b1;
            end else if (in_we_c) begin
                state_d = SCALAR;
                lane_d  = 3'd0;
            end else begin
                state_d = IDLE;
                lane_d  = 3'd0;
            end
        end
    end

    // State and registered outputs; reset aborts any vector in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            Rg_WB     <= '0;
            DinC      <= '0;
            WE_C      <= 1'b0;
            DinV_8bit <= '0;
            WE_V      <= 1'b0;
            wb_lane   <= 3'd0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            Rg_WB     <= rg_d;
            DinC      <= dinc_d;
            WE_C      <= we_c_d;
            DinV_8bit <= dinv_d;
            WE_V      <= we_v_d;
            wb_lane   <= lane_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_wb_vector_serializer.sv
// Directed self-checking bench for wb_vector_serializer (follows WB_LANE_MSB_FIRST_EN lane order).
module tb_wb_vector_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_we_c, in_we_v, in_sel_dat;
    logic [31:0] in_alu_res, in_mem_data;
    logic [39:0] in_vec_res;
    logic [3:0]  in_rg;
    logic [3:0]  Rg_WB;
    logic [31:0] DinC;
    logic        WE_C;
    logic [7:0]  DinV_8bit;
    logic        WE_V;
    logic [2:0]  wb_lane;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    wb_vector_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_we_c    (in_we_c),
        .in_we_v    (in_we_v),
        .in_sel_dat (in_sel_dat),
        .in_alu_res (in_alu_res),
        .in_mem_data(in_mem_data),
        .in_vec_res (in_vec_res),
        .in_rg      (in_rg),
        .Rg_WB      (Rg_WB),
        .DinC       (DinC),
        .WE_C       (WE_C),
        .DinV_8bit  (DinV_8bit),
        .WE_V       (WE_V),
        .wb_lane    (wb_lane),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lane_of(input int i);
`ifdef WB_LANE_MSB_FIRST_EN
        return 4 - i;
`else
        return i;
`endif
    endfunction

    task automatic drive(input logic v, input logic c, input logic vv, input logic sel,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [39:0] vec, input logic [3:0] rg);
        in_valid = v; in_we_c = c; in_we_v = vv; in_sel_dat = sel;
        in_alu_res = alu; in_mem_data = mem; in_vec_res = vec; in_rg = rg;
    endtask

    // Walk all five lanes; the caller has just made the accepting edge. Leaves time at the final lane.
    task automatic check_lanes(input string tag, input logic [39:0] vec, input logic [3:0] rg,
                               input logic c_first, input logic [31:0] dinc);
        for (int i = 0; i < 5; i++) begin
            int l;
            logic [7:0] b;
            l = lane_of(i);
            b = 8'((vec >> (8 * l)) & 40'hFF);
            check({tag, "_we_v"}, 64'(WE_V), 64'd1);
            check({tag, "_dinv"}, 64'(DinV_8bit), 64'(b));
            check({tag, "_lane"}, 64'(wb_lane), 64'(l));
            check({tag, "_rg"}, 64'(Rg_WB), 64'(rg));
            check({tag, "_busy"}, 64'(busy), 64'd1);
            check({tag, "_rdy"}, 64'(in_ready), (i == 4) ? 64'd1 : 64'd0);
            check({tag, "_we_c"}, 64'(WE_C), (c_first && i == 0) ? 64'd1 : 64'd0);
            if (c_first && i == 0) check({tag, "_dinc"}, 64'(DinC), 64'(dinc));
            if (i < 4) tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, '0, '0, '0, '0);
        #13;
        check("rst_we_c", 64'(WE_C), 64'd0);
        check("rst_we_v", 64'(WE_V), 64'd0);
        check("rst_rdy", 64'(in_ready), 64'd1);
        check("rst_outs", {25'd0, Rg_WB, DinC, DinV_8bit, wb_lane, busy}, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Scalar from ALU, then from memory
        drive(1, 1, 0, 0, 32'h12345678, 32'h0BADF00D, 40'hFFFFFFFFFF, 4'd3);
        check("sc1_rdy", 64'(in_ready), 64'd1);
        tick();
        drive(0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, '0, 4'd15);
        check("sc1_we_c", 64'(WE_C), 64'd1);
        check("sc1_dinc", 64'(DinC), 64'h12345678);
        check("sc1_rg", 64'(Rg_WB), 64'd3);
        check("sc1_we_v", 64'(WE_V), 64'd0);
        tick();
        check("sc1_idle", 64'(WE_C), 64'd0);
        drive(1, 1, 0, 1, 32'h55555555, 32'hDEADBEEF, '0, 4'd5);
        tick();
        drive(0, 0, 0, 0, '0, '0, '0, '0);
        check("sc2_we_c", 64'(WE_C), 64'd1);
        check("sc2_dinc", 64'(DinC), 64'hDEADBEEF);
        check("sc2_rg", 64'(Rg_WB), 64'd5);
        tick();

        // Plain vector
        drive(1, 0, 1, 0, '0, '0, 40'h0504030201, 4'd7);
        tick();
        drive(0, 1, 1, 1, 32'hFFFFFFFF, '1, 40'hEEEEEEEEEE, 4'd1);
        check_lanes("vec", 40'h0504030201, 4'd7, 1'b0, '0);
        tick();
        check("vec_end_we_v", 64'(WE_V), 64'd0);
        check("vec_end_busy", 64'(busy), 64'd0);
        check("vec_end_rdy", 64'(in_ready), 64'd1);

        // Back-to-back: vector followed by a held scalar, then a scalar each cycle
        drive(1, 0, 1, 0, '0, '0, 40'hA5A4A3A2A1, 4'd2);
        tick();
        drive(1, 1, 0, 0, 32'h11110000, '0, 40'h0, 4'd9);
        check_lanes("b2b", 40'hA5A4A3A2A1, 4'd2, 1'b0, '0);
        tick();
        check("b2b_s0_we_c", 64'(WE_C), 64'd1);
        check("b2b_s0_dinc", 64'(DinC), 64'h11110000);
        check("b2b_s0_rg", 64'(Rg_WB), 64'd9);
        check("b2b_s0_we_v", 64'(WE_V), 64'd0);
        check("b2b_s0_rdy", 64'(in_ready), 64'd1);
        drive(1, 1, 0, 0, 32'h22220001, '0, '0, 4'd10);
        tick();
        check("b2b_s1_we_c", 64'(WE_C), 64'd1);
        check("b2b_s1_dinc", 64'(DinC), 64'h22220001);
        check("b2b_s1_rg", 64'(Rg_WB), 64'd10);
        drive(1, 1, 0, 0, 32'h33330002, '0, '0, 4'd11);
        tick();
        drive(0, 0, 0, 0, '0, '0, '0, '0);
        check("b2b_s2_dinc", 64'(DinC), 64'h33330002);
        tick();
        check("b2b_idle_we_c", 64'(WE_C), 64'd0);

        // Combined scalar+vector
        drive(1, 1, 1, 0, 32'hCAFEF00D, 32'h0, 40'h1020304050, 4'd4);
        tick();
        drive(0, 0, 0, 0, '0, '0, '0, '0);
        check_lanes("comb", 40'h1020304050, 4'd4, 1'b1, 32'hCAFEF00D);
        tick();
        check("comb_end_we_v", 64'(WE_V), 64'd0);

        // Neither enable: consumed, no write
        drive(1, 0, 0, 1, 32'h1, 32'h2, 40'h3, 4'd6);
        tick();
        drive(0, 0, 0, 0, '0, '0, '0, '0);
        check("none_we_c", 64'(WE_C), 64'd0);
        check("none_we_v", 64'(WE_V), 64'd0);
        check("none_busy", 64'(busy), 64'd0);
        check("none_rdy", 64'(in_ready), 64'd1);
        tick();
        check("none_idle_we", {62'd0, WE_C, WE_V}, 64'd0);

        // Abort during the third emitted lane
        drive(1, 0, 1, 0, '0, '0, 40'h0504030201, 4'd7);
        tick();
        drive(0, 0, 0, 0, '0, '0, '0, '0);
        tick();
        tick();
        check("abort_pre_we_v", 64'(WE_V), 64'd1);
        check("abort_pre_lane", 64'(wb_lane), 64'(lane_of(2)));
        #2 rst = 1'b1;
        #1;
        check("abort_we_v", 64'(WE_V), 64'd0);
        check("abort_we_c", 64'(WE_C), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_rdy", 64'(in_ready), 64'd1);
        check("abort_outs", {25'd0, Rg_WB, DinC, DinV_8bit, wb_lane, busy}, 64'd0);
        tick();
        check("abort_hold_we_v", 64'(WE_V), 64'd0);
        rst = 1'b0;
        tick();
        check("abort_rel_we_v", 64'(WE_V), 64'd0);
        drive(1, 0, 1, 0, '0, '0, 40'h0A0B0C0D0E, 4'd8);
        tick();
        drive(0, 0, 0, 0, '0, '0, '0, '0);
        check_lanes("post", 40'h0A0B0C0D0E, 4'd8, 1'b0, '0);
        tick();
        check("post_end_we_v", 64'(WE_V), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
